// File: rtl/kanagawa_hal_fifo_pkg.sv
// Shared FIFO helpers: occupancy counter width only.
package kanagawa_hal_fifo_pkg;

  // Occupancy must represent 0..depth inclusive, so one bit wider than a pointer.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kanagawa_hal_show_ahead_fifo_if.sv
// Push/pop handshake and status bundle for the show-ahead FIFO.
interface kanagawa_hal_show_ahead_fifo_if
  import kanagawa_hal_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CntW = occ_width(DEPTH);

  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             full;
  logic             almost_full;
  logic [CntW-1:0]  usedw;
  logic             rdreq;
  logic             empty;
  logic             almost_empty;
  logic [WIDTH-1:0] q;

  modport master (
    output wrreq, data, rdreq,
    input  full, almost_full, usedw, empty, almost_empty, q
  );

  modport slave (
    input  wrreq, data, rdreq,
    output full, almost_full, usedw, empty, almost_empty, q
  );
endinterface

// File: rtl/kanagawa_hal_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module kanagawa_hal_fifo_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/kanagawa_hal_show_ahead_fifo.sv
// Show-ahead FIFO: head word is on q with no read latency; rdreq acknowledges it.
// Define KANAGAWA_FIFO_ASSERT_EN to compile simulation legality/parameter checks.
module kanagawa_hal_show_ahead_fifo
  import kanagawa_hal_fifo_pkg::*;
#(
  parameter int unsigned DEPTH                      = 32,
  parameter int unsigned WIDTH                      = 32,
  parameter int unsigned ALMOSTFULL_ENTRIES         = 0,
  parameter int unsigned OVER_UNDER_FLOW_PROTECTION = 1
) (
  input logic                          clock,
  input logic                          rst,
  kanagawa_hal_show_ahead_fifo_if.slave fifo_if
);
  localparam int unsigned LOG_DEPTH = $clog2(DEPTH);
  localparam int unsigned CntW      = occ_width(DEPTH);

  localparam logic [CntW-1:0]      CntDepth = CntW'(DEPTH);
  localparam logic [CntW-1:0]      CntAfull = CntW'(DEPTH - ALMOSTFULL_ENTRIES);
  localparam logic [CntW-1:0]      CntOne   = CntW'(1);
  localparam logic [LOG_DEPTH-1:0] PtrOne   = LOG_DEPTH'(1);

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      usedw_q, usedw_d;
  logic                 full, empty;
  logic                 push, pop;

  // Status flags derive from the registered count only.
  assign full  = (usedw_q == CntDepth);
  assign empty = (usedw_q == '0);

  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (usedw_q >= CntAfull);
  assign fifo_if.almost_empty = (usedw_q <= CntOne);
  assign fifo_if.usedw        = usedw_q;

  // Qualify requests; with protection off the caller owns legality.
  always_comb begin
    push = fifo_if.wrreq;
    pop  = fifo_if.rdreq;
    if (OVER_UNDER_FLOW_PROTECTION != 0) begin
      push = fifo_if.wrreq && !full;
      pop  = fifo_if.rdreq && !empty;
    end
  end

  // Next pointer and occupancy; simultaneous push/pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   usedw_d = usedw_q + CntOne;
      2'b01:   usedw_d = usedw_q - CntOne;
      default: usedw_d = usedw_q;
    endcase
  end

  // State register with synchronous reset taking priority over requests.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  kanagawa_hal_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (push && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_if.data),
    .raddr_i (rd_ptr_q),
    .rdata_o (fifo_if.q)
  );

`ifdef KANAGAWA_FIFO_ASSERT_EN
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("kanagawa_hal_show_ahead_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (ALMOSTFULL_ENTRIES >= DEPTH) begin : g_bad_afull
    $error("kanagawa_hal_show_ahead_fifo: ALMOSTFULL_ENTRIES must be below DEPTH");
  end

  // Unprotected mode: flag illegal requests from the caller.
  always @(posedge clock) begin
    if (!rst && (OVER_UNDER_FLOW_PROTECTION == 0)) begin
      if (fifo_if.wrreq && full)  $error("kanagawa_hal_show_ahead_fifo: push while full");
      if (fifo_if.rdreq && empty) $error("kanagawa_hal_show_ahead_fifo: pop while empty");
    end
  end
`endif
endmodule

// File: tb/tb_kanagawa_hal_show_ahead_fifo.sv
// Self-checking bench for the show-ahead FIFO (DEPTH=4, ALMOSTFULL_ENTRIES=1).
module tb_kanagawa_hal_show_ahead_fifo;
  logic clock;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic [7:0] exp_q[$];

  kanagawa_hal_show_ahead_fifo_if #(.DEPTH(4), .WIDTH(8)) fif ();

  kanagawa_hal_show_ahead_fifo #(
    .DEPTH                      (4),
    .WIDTH                      (8),
    .ALMOSTFULL_ENTRIES         (1),
    .OVER_UNDER_FLOW_PROTECTION (1)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .fifo_if (fif.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of requests and update the reference queue.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    bit acc_push, acc_pop;
    fif.wrreq = wr;
    fif.data  = d;
    fif.rdreq = rd;
    acc_push  = wr && (model_cnt < 4);
    acc_pop   = rd && (model_cnt > 0);
    if (acc_pop)  void'(exp_q.pop_front());
    if (acc_push) exp_q.push_back(d);
    model_cnt = model_cnt + int'(acc_push) - int'(acc_pop);
    @(posedge clock);
    #1;
    fif.wrreq = 1'b0;
    fif.rdreq = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 16) begin
      checks++;
      if (fif.q !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_order: q=%h expected=%h", name, fif.q, exp_q[0]);
      end
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    checks++;
    if (fif.empty !== 1'b1 || fif.usedw !== 3'd0) begin
      errors++;
      $display("FAIL %s_drained: empty=%b usedw=%0d expected empty=1 usedw=0",
               name, fif.empty, fif.usedw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (fif.empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b expected 1", fif.empty); end
    checks++; if (fif.full !== 1'b0) begin errors++;
      $display("FAIL reset_full: got %b expected 0", fif.full); end
    checks++; if (fif.usedw !== 3'd0) begin errors++;
      $display("FAIL reset_usedw: got %0d expected 0", fif.usedw); end
    checks++; if (fif.almost_empty !== 1'b1) begin errors++;
      $display("FAIL reset_almost_empty: got %b expected 1", fif.almost_empty); end
    checks++; if (fif.almost_full !== 1'b0) begin errors++;
      $display("FAIL reset_almost_full: got %b expected 0", fif.almost_full); end
  endtask

  task automatic test_single();
    step(1'b1, 8'hA1, 1'b0);
    checks++; if (fif.empty !== 1'b0) begin errors++;
      $display("FAIL single_empty: got %b expected 0", fif.empty); end
    checks++; if (fif.q !== 8'hA1) begin errors++;
      $display("FAIL single_q: got %h expected a1", fif.q); end
    checks++; if (fif.usedw !== 3'd1) begin errors++;
      $display("FAIL single_usedw: got %0d expected 1", fif.usedw); end
    checks++; if (fif.almost_empty !== 1'b1) begin errors++;
      $display("FAIL single_almost_empty: got %b expected 1", fif.almost_empty); end
    drain("single");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    checks++; if (fif.almost_full !== 1'b1 || fif.full !== 1'b0) begin errors++;
      $display("FAIL fill3_flags: almost_full=%b full=%b expected 1 0",
               fif.almost_full, fif.full); end
    checks++; if (fif.almost_empty !== 1'b0 || fif.usedw !== 3'd3) begin errors++;
      $display("FAIL fill3_count: almost_empty=%b usedw=%0d expected 0 3",
               fif.almost_empty, fif.usedw); end
    step(1'b1, 8'h13, 1'b0);
    checks++; if (fif.full !== 1'b1) begin errors++;
      $display("FAIL fill4_full: got %b expected 1", fif.full); end
    step(1'b1, 8'h14, 1'b0);
    checks++; if (fif.usedw !== 3'd4 || fif.full !== 1'b1) begin errors++;
      $display("FAIL overflow_ignored: usedw=%0d full=%b expected 4 1", fif.usedw, fif.full); end
    // Push+pop while full: push is blocked, pop completes.
    checks++; if (fif.q !== exp_q[0]) begin errors++;
      $display("FAIL full_pushpop_head: q=%h expected=%h", fif.q, exp_q[0]); end
    step(1'b1, 8'h15, 1'b1);
    checks++; if (fif.usedw !== 3'd3 || fif.full !== 1'b0) begin errors++;
      $display("FAIL full_pushpop_usedw: usedw=%0d full=%b expected 3 0", fif.usedw, fif.full); end
    drain("fill");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i % 2 == 1) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (fif.q !== exp_q[0]) begin
            errors++;
            $display("FAIL wrap_order: q=%h expected=%h", fif.q, exp_q[0]);
          end
          step(1'b0, 8'h00, 1'b1);
        end
      end
    end
    checks++; if (fif.empty !== 1'b1) begin errors++;
      $display("FAIL wrap_end_empty: got %b expected 1", fif.empty); end
  endtask

  task automatic test_simul();
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    checks++; if (fif.q !== exp_q[0]) begin errors++;
      $display("FAIL simul_head: q=%h expected=%h", fif.q, exp_q[0]); end
    step(1'b1, 8'h77, 1'b1);
    checks++; if (fif.usedw !== 3'd2) begin errors++;
      $display("FAIL simul_usedw: got %0d expected 2", fif.usedw); end
    drain("simul");
    // Pop while empty is ignored.
    step(1'b0, 8'h00, 1'b1);
    checks++; if (fif.usedw !== 3'd0 || fif.empty !== 1'b1) begin errors++;
      $display("FAIL underflow_ignored: usedw=%0d empty=%b expected 0 1", fif.usedw, fif.empty); end
    // Push+pop while empty: pop ignored, word lands.
    step(1'b1, 8'h88, 1'b1);
    checks++; if (fif.usedw !== 3'd1 || fif.q !== 8'h88) begin errors++;
      $display("FAIL empty_pushpop: usedw=%0d q=%h expected 1 88", fif.usedw, fif.q); end
    drain("empty_pushpop");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    checks++; if (fif.usedw !== 3'd3) begin errors++;
      $display("FAIL rstmid_pre_usedw: got %0d expected 3", fif.usedw); end
    rst       = 1'b1;
    fif.wrreq = 1'b1;
    fif.data  = 8'hEE;
    @(posedge clock);
    #1;
    rst       = 1'b0;
    fif.wrreq = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    checks++; if (fif.usedw !== 3'd0 || fif.empty !== 1'b1) begin errors++;
      $display("FAIL rstmid_usedw: usedw=%0d empty=%b expected 0 1", fif.usedw, fif.empty); end
    step(1'b1, 8'h3C, 1'b0);
    checks++; if (fif.q !== 8'h3C || fif.usedw !== 3'd1) begin errors++;
      $display("FAIL rstmid_after: q=%h usedw=%0d expected 3c 1", fif.q, fif.usedw); end
    drain("rstmid");
  endtask

  initial begin
    rst       = 1'b1;
    fif.wrreq = 1'b0;
    fif.rdreq = 1'b0;
    fif.data  = '0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
